// File: rtl/hdr_capture_pkg.sv
// Shared types and constants for the header capture buffer.
package hdr_capture_pkg;

    localparam int unsigned LEN_W         = 16;
    localparam int unsigned MIN_ETH_BYTES = 14;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/hdr_capture_buf_keep_popcnt.sv
// Combinational popcount of a byte-enable vector.
module keep_popcnt #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]       i_keep,
    output logic [$clog2(W):0] o_cnt_c
);

    localparam int unsigned CW = $clog2(W) + 1;

    always_comb begin
        o_cnt_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            o_cnt_c = o_cnt_c + CW'(i_keep[i]);
        end
    end

endmodule

// File: rtl/hdr_capture_buf.sv
// Single-entry header capture buffer: stores the first HEADER_BYTES of a packet and its length.
// Optional runt dropping is enabled by defining HDR_CAPTURE_RUNT_DROP_EN.
module hdr_capture_buf
    import hdr_capture_pkg::*;
#(
    parameter int unsigned HEADER_BYTES = 192,
    parameter int unsigned BEAT_BYTES   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*BEAT_BYTES-1:0]   s_tdata,
    input  logic [BEAT_BYTES-1:0]     s_tkeep,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic                      hdr_valid,
    output logic [8*HEADER_BYTES-1:0] hdr_flat,
    input  logic                      hdr_ready,
    output logic [LEN_W-1:0]          pkt_len,
    output logic [LEN_W-1:0]          hdr_bytes,
    output logic                      truncated,
    output logic [LEN_W-1:0]          runt_drop_cnt
);

    localparam int unsigned HDR_W = 8 * HEADER_BYTES;
    localparam int unsigned CNT_W = $clog2(BEAT_BYTES) + 1;
    localparam int unsigned IDX_W = $clog2(HEADER_BYTES);
    localparam int unsigned SUM_W = LEN_W + 1;
    localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(HEADER_BYTES);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t             r_state, w_state_nxt;
    logic               r_hdr_valid;
    logic [LEN_W-1:0]   r_byte_cnt, w_byte_cnt_nxt;
    logic [HDR_W-1:0]   r_hdr_flat, w_hdr_flat_nxt;
    logic [LEN_W-1:0]   r_pkt_len, r_hdr_bytes;
    logic               r_truncated;
    logic [CNT_W-1:0]   w_pop;
    logic [SUM_W-1:0]   w_sum_raw;
    logic [LEN_W-1:0]   w_sum;
    logic               w_accept, w_done, w_runt, w_clear;

    keep_popcnt #(.W(BEAT_BYTES)) u_popcnt (
        .i_keep  (s_tkeep),
        .o_cnt_c (w_pop)
    );

    assign s_tready  = rst_n && (r_state != S_HOLD);
    assign w_accept  = s_tvalid && s_tready;
    assign w_done    = w_accept && s_tlast;
    assign w_sum_raw = {1'b0, r_byte_cnt} + SUM_W'(w_pop);
    assign w_sum     = w_sum_raw[LEN_W] ? LEN_MAX : w_sum_raw[LEN_W-1:0];

`ifdef HDR_CAPTURE_RUNT_DROP_EN
    assign w_runt = w_done && (w_sum < LEN_W'(MIN_ETH_BYTES));
`else
    assign w_runt = 1'b0;
`endif

    // A dropped runt and a completed handshake both return the buffer to empty.
    assign w_clear = w_runt || (r_hdr_valid && hdr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_hdr_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hdr_valid <= (w_state_nxt == S_HOLD);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FILL: begin
                if (w_done)
                    w_state_nxt = w_runt ? S_FILL : S_HOLD;
                else if (w_accept && (w_sum >= HDR_LEN))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_done)
                    w_state_nxt = w_runt ? S_FILL : S_HOLD;
            end
            S_HOLD: begin
                if (hdr_ready)
                    w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Lanes landing at or past the header boundary are counted but not stored.
    always_comb begin
        logic [SUM_W-1:0] pos;
        pos            = '0;
        w_hdr_flat_nxt = r_hdr_flat;
        w_byte_cnt_nxt = r_byte_cnt;
        if (w_clear) begin
            w_hdr_flat_nxt = '0;
            w_byte_cnt_nxt = '0;
        end else if (w_accept) begin
            w_byte_cnt_nxt = w_sum;
            for (int i = 0; i < int'(BEAT_BYTES); i++) begin
                pos = {1'b0, r_byte_cnt} + SUM_W'(i);
                if (s_tkeep[i] && (pos < {1'b0, HDR_LEN}))
                    w_hdr_flat_nxt[{IDX_W'(pos), 3'b000} +: 8] = s_tdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= '0;
            r_hdr_flat  <= '0;
            r_pkt_len   <= '0;
            r_hdr_bytes <= '0;
            r_truncated <= 1'b0;
        end else begin
            r_byte_cnt <= w_byte_cnt_nxt;
            r_hdr_flat <= w_hdr_flat_nxt;
            if (w_done && !w_runt) begin
                r_pkt_len   <= w_sum;
                r_hdr_bytes <= (w_sum > HDR_LEN) ? HDR_LEN : w_sum;
                r_truncated <= (w_sum > HDR_LEN);
            end
        end
    end

`ifdef HDR_CAPTURE_RUNT_DROP_EN
    logic [LEN_W-1:0] r_runt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_runt_cnt <= '0;
        else if (w_runt && (r_runt_cnt != LEN_MAX))
            r_runt_cnt <= r_runt_cnt + LEN_W'(1);
    end

    assign runt_drop_cnt = r_runt_cnt;
`else
    assign runt_drop_cnt = '0;
`endif

    assign hdr_valid = r_hdr_valid;
    assign hdr_flat  = r_hdr_flat;
    assign pkt_len   = r_pkt_len;
    assign hdr_bytes = r_hdr_bytes;
    assign truncated = r_truncated;

endmodule

// File: tb/tb_hdr_capture_buf.sv
// Scoreboard bench for hdr_capture_buf; honours HDR_CAPTURE_RUNT_DROP_EN when defined.
module tb_hdr_capture_buf;

    localparam int HB = 192;
    localparam int BB = 8;
    localparam int HW = 8 * HB;
    localparam int DW = 8 * BB;

    typedef logic [7:0] byte_t;
    typedef byte_t bq_t[$];
    typedef struct packed {
        logic [15:0] len;
        logic [15:0] hb;
        logic        trunc;
    } meta_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [BB-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          hdr_valid;
    logic [HW-1:0] hdr_flat;
    logic          hdr_ready;
    logic [15:0]   pkt_len;
    logic [15:0]   hdr_bytes;
    logic          truncated;
    logic [15:0]   runt_drop_cnt;

    logic [HW-1:0] flat_q[$];
    meta_t         meta_q[$];
    int            cmp_cnt;
    int            fail_cnt;
    int            exp_runt;

    hdr_capture_buf #(.HEADER_BYTES(HB), .BEAT_BYTES(BB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .hdr_valid     (hdr_valid),
        .hdr_flat      (hdr_flat),
        .hdr_ready     (hdr_ready),
        .pkt_len       (pkt_len),
        .hdr_bytes     (hdr_bytes),
        .truncated     (truncated),
        .runt_drop_cnt (runt_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_diff(input logic [HW-1:0] a, input logic [HW-1:0] b);
        for (int i = 0; i < HB; i++)
            if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        return 0;
    endfunction

    function automatic meta_t obs_meta();
        meta_t m;
        m.len   = pkt_len;
        m.hb    = hdr_bytes;
        m.trunc = truncated;
        return m;
    endfunction

    task automatic mk_pkt(input int n, input bit ramp, output bq_t d);
        d = {};
        for (int i = 0; i < n; i++)
            d.push_back(ramp ? byte_t'(i) : byte_t'($urandom));
    endtask

    // Drives at negedges; a beat is taken at the next posedge when s_tready is seen high.
    task automatic send_pkt(input bq_t d, input int gap_pct, input bit expect_out, output int stalls);
        int            nbeats;
        int            n;
        logic [HW-1:0] ef;
        meta_t         em;
        n      = d.size();
        nbeats = (n + BB - 1) / BB;
        if (nbeats == 0) nbeats = 1;
        stalls = 0;
        if (expect_out) begin
            ef = '0;
            for (int i = 0; i < n && i < HB; i++) ef[8*i +: 8] = d[i];
            em.len   = (n > 65535) ? 16'hFFFF : 16'(n);
            em.hb    = (n > HB) ? 16'(HB) : 16'(n);
            em.trunc = (n > HB);
            flat_q.push_back(ef);
            meta_q.push_back(em);
        end
        for (int b = 0; b < nbeats; b++) begin
            int w;
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                s_tvalid = 1'b0;
                @(negedge clk);
            end
            s_tdata = {$urandom, $urandom};
            s_tkeep = '0;
            for (int l = 0; l < BB; l++) begin
                if (b * BB + l < n) begin
                    s_tdata[8*l +: 8] = d[b * BB + l];
                    s_tkeep[l]        = 1'b1;
                end
            end
            s_tlast  = (b == nbeats - 1);
            s_tvalid = 1'b1;
            w = 0;
            while (!s_tready) begin
                stalls++;
                w++;
                @(negedge clk);
                if (w > 2000) begin
                    cmp_cnt++;
                    fail_cnt++;
                    $display("FAIL send_timeout: s_tready got 0 for %0d cycles want 1", w);
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        cmp_cnt++;
        if (hdr_valid !== 1'b0 || s_tready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL rst_hs: got valid=%b ready=%b want valid=0 ready=1", hdr_valid, s_tready);
        end
        cmp_cnt++;
        if (hdr_flat !== '0) begin
            fail_cnt++;
            $display("FAIL rst_flat: byte %0d got %h want 00", first_diff(hdr_flat, '0), hdr_flat[8*first_diff(hdr_flat, '0) +: 8]);
        end
        cmp_cnt++;
        if (obs_meta() !== meta_t'(0) || runt_drop_cnt !== 16'd0) begin
            fail_cnt++;
            $display("FAIL rst_meta: got len=%0d hb=%0d tr=%b runt=%0d want all 0", pkt_len, hdr_bytes, truncated, runt_drop_cnt);
        end
    endtask

    task automatic test_basic_64();
        bq_t d; int st, k; logic [HW-1:0] ef; meta_t em;
        mk_pkt(64, 1'b1, d);
        send_pkt(d, 0, 1'b1, st);
        ef = flat_q.pop_front(); em = meta_q.pop_front();
        cmp_cnt++;
        if (hdr_valid !== 1'b1) begin fail_cnt++; $display("FAIL b64_latency: hdr_valid got %b want 1", hdr_valid); end
        cmp_cnt++;
        if (hdr_flat !== ef) begin
            fail_cnt++; k = first_diff(hdr_flat, ef);
            $display("FAIL b64_flat: byte %0d got %h want %h", k, hdr_flat[8*k +: 8], ef[8*k +: 8]);
        end
        cmp_cnt++;
        if (obs_meta() !== em) begin
            fail_cnt++;
            $display("FAIL b64_meta: got len=%0d hb=%0d tr=%b want len=%0d hb=%0d tr=%b", pkt_len, hdr_bytes, truncated, em.len, em.hb, em.trunc);
        end
        @(negedge clk);
        cmp_cnt++;
        if (hdr_valid !== 1'b0 || s_tready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL b64_handshake: got valid=%b ready=%b want valid=0 ready=1", hdr_valid, s_tready);
        end
    endtask

    task automatic test_truncated();
        int sizes[2] = '{300, 66000};
        bq_t d; int st, k; logic [HW-1:0] ef; meta_t em;
        foreach (sizes[s]) begin
            mk_pkt(sizes[s], 1'b0, d);
            send_pkt(d, 0, 1'b1, st);
            ef = flat_q.pop_front(); em = meta_q.pop_front();
            cmp_cnt++;
            if (st !== 0) begin fail_cnt++; $display("FAIL trunc_ready_%0d: stall cycles got %0d want 0", sizes[s], st); end
            cmp_cnt++;
            if (hdr_valid !== 1'b1) begin fail_cnt++; $display("FAIL trunc_valid_%0d: got %b want 1", sizes[s], hdr_valid); end
            cmp_cnt++;
            if (hdr_flat !== ef) begin
                fail_cnt++; k = first_diff(hdr_flat, ef);
                $display("FAIL trunc_flat_%0d: byte %0d got %h want %h", sizes[s], k, hdr_flat[8*k +: 8], ef[8*k +: 8]);
            end
            cmp_cnt++;
            if (obs_meta() !== em) begin
                fail_cnt++;
                $display("FAIL trunc_meta_%0d: got len=%0d hb=%0d tr=%b want len=%0d hb=%0d tr=%b", sizes[s], pkt_len, hdr_bytes, truncated, em.len, em.hb, em.trunc);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bq_t da, db; int st, stb, k; logic [HW-1:0] ef, efa; meta_t em;
        hdr_ready = 1'b0;
        mk_pkt(100, 1'b0, da);
        mk_pkt(40, 1'b0, db);
        send_pkt(da, 0, 1'b1, st);
        efa = flat_q.pop_front(); em = meta_q.pop_front();
        cmp_cnt++;
        if (hdr_valid !== 1'b1 || obs_meta() !== em) begin
            fail_cnt++;
            $display("FAIL hold_a: got valid=%b len=%0d want valid=1 len=%0d", hdr_valid, pkt_len, em.len);
        end
        fork
            send_pkt(db, 0, 1'b1, stb);
            begin
                for (int c = 0; c < 10; c++) begin
                    cmp_cnt++;
                    if (s_tready !== 1'b0 || hdr_valid !== 1'b1 || hdr_flat !== efa) begin
                        fail_cnt++;
                        $display("FAIL hold_stable_c%0d: got ready=%b valid=%b flat_byte%0d=%h want ready=0 valid=1 flat unchanged",
                                 c, s_tready, hdr_valid, first_diff(hdr_flat, efa), hdr_flat[8*first_diff(hdr_flat, efa) +: 8]);
                    end
                    @(negedge clk);
                end
                hdr_ready = 1'b1;
                @(negedge clk);
                cmp_cnt++;
                if (hdr_valid !== 1'b0 || s_tready !== 1'b1) begin
                    fail_cnt++;
                    $display("FAIL hold_release: got valid=%b ready=%b want valid=0 ready=1", hdr_valid, s_tready);
                end
            end
        join
        ef = flat_q.pop_front(); em = meta_q.pop_front();
        cmp_cnt++;
        if (stb !== 11) begin fail_cnt++; $display("FAIL hold_b_stalls: got %0d want 11", stb); end
        cmp_cnt++;
        if (hdr_valid !== 1'b1) begin fail_cnt++; $display("FAIL hold_b_valid: got %b want 1", hdr_valid); end
        cmp_cnt++;
        if (hdr_flat !== ef) begin
            fail_cnt++; k = first_diff(hdr_flat, ef);
            $display("FAIL hold_b_flat: byte %0d got %h want %h", k, hdr_flat[8*k +: 8], ef[8*k +: 8]);
        end
        cmp_cnt++;
        if (obs_meta() !== em) begin
            fail_cnt++;
            $display("FAIL hold_b_meta: got len=%0d hb=%0d tr=%b want len=%0d hb=%0d tr=%b", pkt_len, hdr_bytes, truncated, em.len, em.hb, em.trunc);
        end
        @(negedge clk);
    endtask

    task automatic test_runt();
        int sizes[4] = '{10, 0, 13, 14};
        bq_t d; int st, k; bit drop; logic seen; logic [HW-1:0] ef; meta_t em;
        foreach (sizes[s]) begin
`ifdef HDR_CAPTURE_RUNT_DROP_EN
            drop = (sizes[s] < 14);
`else
            drop = 1'b0;
`endif
            mk_pkt(sizes[s], 1'b0, d);
            send_pkt(d, 0, !drop, st);
            if (drop) begin
                exp_runt++;
                cmp_cnt++;
                if (hdr_flat !== '0) begin fail_cnt++; $display("FAIL runt_clear_%0d: flat byte %0d nonzero", sizes[s], first_diff(hdr_flat, '0)); end
                seen = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    seen = seen | hdr_valid;
                    @(negedge clk);
                end
                cmp_cnt++;
                if (seen !== 1'b0) begin fail_cnt++; $display("FAIL runt_novalid_%0d: hdr_valid seen %b want 0", sizes[s], seen); end
            end else begin
                ef = flat_q.pop_front(); em = meta_q.pop_front();
                cmp_cnt++;
                if (hdr_valid !== 1'b1) begin fail_cnt++; $display("FAIL runt_fwd_valid_%0d: got %b want 1", sizes[s], hdr_valid); end
                cmp_cnt++;
                if (hdr_flat !== ef) begin
                    fail_cnt++; k = first_diff(hdr_flat, ef);
                    $display("FAIL runt_fwd_flat_%0d: byte %0d got %h want %h", sizes[s], k, hdr_flat[8*k +: 8], ef[8*k +: 8]);
                end
                cmp_cnt++;
                if (obs_meta() !== em) begin
                    fail_cnt++;
                    $display("FAIL runt_fwd_meta_%0d: got len=%0d hb=%0d tr=%b want len=%0d hb=%0d tr=%b", sizes[s], pkt_len, hdr_bytes, truncated, em.len, em.hb, em.trunc);
                end
                @(negedge clk);
            end
            cmp_cnt++;
            if (runt_drop_cnt !== 16'(exp_runt)) begin
                fail_cnt++;
                $display("FAIL runt_cnt_%0d: got %0d want %0d", sizes[s], runt_drop_cnt, exp_runt);
            end
        end
    endtask

    task automatic test_gaps();
        int gaps[2] = '{0, 40};
        bq_t d; int st, k; logic [HW-1:0] ef; meta_t em;
        mk_pkt(100, 1'b0, d);
        foreach (gaps[g]) begin
            send_pkt(d, gaps[g], 1'b1, st);
            ef = flat_q.pop_front(); em = meta_q.pop_front();
            cmp_cnt++;
            if (hdr_valid !== 1'b1) begin fail_cnt++; $display("FAIL gap%0d_valid: got %b want 1", gaps[g], hdr_valid); end
            cmp_cnt++;
            if (hdr_flat !== ef) begin
                fail_cnt++; k = first_diff(hdr_flat, ef);
                $display("FAIL gap%0d_flat: byte %0d got %h want %h", gaps[g], k, hdr_flat[8*k +: 8], ef[8*k +: 8]);
            end
            cmp_cnt++;
            if (obs_meta() !== em) begin
                fail_cnt++;
                $display("FAIL gap%0d_meta: got len=%0d hb=%0d tr=%b want len=%0d hb=%0d tr=%b", gaps[g], pkt_len, hdr_bytes, truncated, em.len, em.hb, em.trunc);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_packet();
        bq_t d; int st, k; logic [HW-1:0] ef; meta_t em;
        for (int b = 0; b < 3; b++) begin
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = '1;
            s_tlast  = 1'b0;
            s_tvalid = 1'b1;
            if (b == 2) rst_n = 1'b0;
            @(negedge clk);
        end
        cmp_cnt++;
        if (hdr_valid !== 1'b0 || s_tready !== 1'b0 || hdr_flat !== '0 || obs_meta() !== meta_t'(0) || runt_drop_cnt !== 16'd0) begin
            fail_cnt++;
            $display("FAIL midrst_outputs: got valid=%b ready=%b flat_byte%0d=%h len=%0d hb=%0d tr=%b runt=%0d want all 0",
                     hdr_valid, s_tready, first_diff(hdr_flat, '0), hdr_flat[8*first_diff(hdr_flat, '0) +: 8],
                     pkt_len, hdr_bytes, truncated, runt_drop_cnt);
        end
        s_tvalid = 1'b0;
        rst_n    = 1'b1;
        exp_runt = 0;
        @(negedge clk);
        mk_pkt(96, 1'b0, d);
        send_pkt(d, 0, 1'b1, st);
        ef = flat_q.pop_front(); em = meta_q.pop_front();
        cmp_cnt++;
        if (hdr_valid !== 1'b1) begin fail_cnt++; $display("FAIL midrst_valid: got %b want 1", hdr_valid); end
        cmp_cnt++;
        if (hdr_flat !== ef) begin
            fail_cnt++; k = first_diff(hdr_flat, ef);
            $display("FAIL midrst_flat: byte %0d got %h want %h", k, hdr_flat[8*k +: 8], ef[8*k +: 8]);
        end
        cmp_cnt++;
        if (obs_meta() !== em) begin
            fail_cnt++;
            $display("FAIL midrst_meta: got len=%0d hb=%0d tr=%b want len=%0d hb=%0d tr=%b", pkt_len, hdr_bytes, truncated, em.len, em.hb, em.trunc);
        end
        @(negedge clk);
    endtask

    initial begin
        cmp_cnt   = 0;
        fail_cnt  = 0;
        exp_runt  = 0;
        rst_n     = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        hdr_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic_64();
        test_truncated();
        test_back_to_back();
        test_runt();
        test_gaps();
        test_reset_mid_packet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/hdr_capture_buf.md
# hdr_capture_buf

Upstream neighbour of the header parser FSM: accepts an ingress packet as a stream of BEAT_BYTES-wide beats, writes the first HEADER_BYTES bytes into a flat header register, and counts the remaining bytes to obtain the total length. It drains the packet tail and presents the result on the hdr_valid/hdr_flat/hdr_ready handshake that the parser consumes. It is a single-entry buffer: the input stalls while a captured header waits for the parser.

## Interface
- HEADER_BYTES, 192, bytes captured into hdr_flat; must match the parser.
- BEAT_BYTES, 8, bytes per input beat; power of 2, 1..32.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_tdata  in  8*BEAT_BYTES  beat data; lane 0 (bits 7:0) is the earliest byte.
- s_tkeep  in  BEAT_BYTES  byte enables; all ones except on the last beat, contiguous from lane 0.
- s_tvalid  in  1  beat valid.
- s_tlast  in  1  last beat of the packet.
- s_tready  out  1  beat accepted when s_tvalid && s_tready.
- hdr_valid  out  1  captured header available.
- hdr_flat  out  8*HEADER_BYTES  packet byte i at bits [8i+7:8i]; zero-padded past the packet end.
- hdr_ready  in  1  consumer accepts the header.
- pkt_len  out  16  total packet bytes; saturates at 16'hFFFF.
- hdr_bytes  out  16  min(pkt_len, HEADER_BYTES).
- truncated  out  1  pkt_len > HEADER_BYTES.
- runt_drop_cnt  out  16  dropped-runt counter; constant 0 when the feature is compiled out.

## Operation
- States:
  - S_FILL: byte_cnt < HEADER_BYTES.
  - S_DRAIN: header is full, counting the tail.
  - S_HOLD: output is valid.
- Accepted beat, per lane i with s_tkeep[i]=1:
  - If byte_cnt+i < HEADER_BYTES, write byte byte_cnt+i.
  - Lanes at or past the boundary are discarded but still counted.
- byte_cnt += popcount(s_tkeep); it saturates at 16'hFFFF and never wraps.
- S_FILL goes to S_DRAIN when byte_cnt reaches HEADER_BYTES without s_tlast. A beat may straddle the boundary.
- Accepted s_tlast in S_FILL or S_DRAIN goes to S_HOLD. At that point pkt_len, hdr_bytes and truncated are latched from the final count.
- S_HOLD with hdr_valid && hdr_ready:
  - hdr_flat is cleared to 0.
  - byte_cnt is cleared.
  - State goes to S_FILL.
- A beat with s_tkeep=0 and s_tlast=1 is legal and adds 0 bytes.
- A packet with 0 bytes yields pkt_len=0 and an all-zero hdr_flat.
- Reset values:
  - state S_FILL.
  - hdr_valid 0, hdr_flat 0, pkt_len 0, hdr_bytes 0, truncated 0, runt_drop_cnt 0, byte_cnt 0.
- Reset asserted mid-packet discards the partial packet. The upstream stream must restart at a packet boundary.

## Timing
- s_tready = rst_n && (state != S_HOLD). It is combinational from state.
- hdr_valid = (state == S_HOLD) and is registered. It rises in the cycle after the s_tlast beat is accepted.
- While hdr_valid=1, hdr_flat, pkt_len, hdr_bytes and truncated are stable until the handshake.
- Handshake cycle: hdr_valid falls and s_tready rises in the next cycle. Minimum gap of 1 idle cycle between packets.
- Latency: an N-beat packet gives hdr_valid at cycle N+1 after its first beat, given no stalls.
- s_tvalid gaps are allowed mid-packet. The state holds; no timeout.

## Configuration
- Macro HDR_CAPTURE_RUNT_DROP_EN.
- Defined:
  - At s_tlast, if the final count < 14 (MIN_ETH_BYTES), the packet is dropped.
  - No S_HOLD and no hdr_valid.
  - hdr_flat and byte_cnt are cleared; state returns to S_FILL next cycle.
  - runt_drop_cnt increments, saturating at 16'hFFFF.
- Undefined: runts are forwarded like any packet, and runt_drop_cnt is tied to 0.

## Structure
- Package hdr_capture_pkg: state encodings, MIN_ETH_BYTES=14, LEN_W=16.
- Sub-module keep_popcnt: combinational popcount of s_tkeep, width BEAT_BYTES, result $clog2(BEAT_BYTES)+1 bits.

## Test plan
- 64-byte packet, 8 full beats with bytes 0x00..0x3F, hdr_ready=1 -> hdr_valid 1 cycle after beat 8; bytes 0..63 match, 64..191 zero; pkt_len=64; hdr_bytes=64; truncated=0.
- 300-byte packet (38 beats, last tkeep=8'h0F) -> bytes 0..191 captured; pkt_len=300; hdr_bytes=192; truncated=1; s_tready stays high through the tail.
- hdr_ready held low 10 cycles after hdr_valid, second packet offered -> s_tready=0, hdr_flat stable; second packet accepted the cycle after the handshake, with no stale bytes from packet 1.
- 10-byte packet (beats tkeep 8'hFF, 8'h03):
  - With macro: no hdr_valid; runt_drop_cnt=1.
  - Without macro: hdr_valid, pkt_len=10.
- rst_n pulsed low during beat 3 of a 12-beat packet -> all outputs 0; the next full packet is captured correctly.
- Random s_tvalid gaps on a 100-byte packet -> results identical to the gap-free run.
